bnn_act_packer: RTL and testbench
=================================

BNN_ACT_PACKER -- requirements
Module: bnn_act_packer

Interface
REQ-001 The block SHALL have parameter POP_W, default 8, giving the width of the per-chunk popcount input.
REQ-002 The block SHALL have parameter SUM_W, default 16, giving the width of the neuron accumulator and threshold.
REQ-003 The block SHALL have parameter PACK_W, default 32, giving the number of activation bits per output word.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic updates on the rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an input beat this cycle.
REQ-008 The block SHALL have port in_pop, input, POP_W bits: the XNOR-popcount of one chunk.
REQ-009 The block SHALL have port in_last, input, 1 bit: this beat is the final chunk of the current neuron.
REQ-010 The block SHALL have port in_thresh, input, SUM_W bits: the neuron threshold, sampled only on the accepted in_last beat.
REQ-011 The block SHALL have port flush, input, 1 bit: emit the partial word (active only with BNN_PACK_FLUSH_EN).
REQ-012 The block SHALL have port out_valid, output, 1 bit: the packed word is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-014 The block SHALL have port out_data, output, PACK_W bits: the packed binary activations.
REQ-015 The block SHALL have port out_count, output, clog2(PACK_W)+1 bits: the number of valid bits in out_data.
REQ-016 The block SHALL have port ovf, output, 1 bit: sticky accumulator saturation flag.

Function
REQ-017 The block SHALL have two FSM states: ACCUM and EMIT; in_ready SHALL be 1 exactly when the state is ACCUM.
REQ-018 An input beat SHALL be accepted when in_valid and in_ready are both 1.
- Accepted beat with in_last=0: sum <= sum + in_pop.
- Arithmetic is unsigned; the accumulator saturates at 2^SUM_W-1.
- On saturation, ovf is set to 1.
REQ-019 On an accepted beat with in_last=1:
- total = sat(sum + in_pop).
- bit = (total > in_thresh), a strict compare.
- pack[idx] <= bit, then idx <= idx+1 and sum <= 0.
- The first neuron goes to bit 0.
REQ-020 When the write at REQ-019 lands in bit PACK_W-1:
- out_data <= pack including the new bit, and out_count <= PACK_W.
- out_valid = 1 on the next cycle; the state goes to EMIT.
- pack and idx are cleared.
REQ-021 In EMIT, out_data and out_count SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 In EMIT, an out_valid and out_ready handshake SHALL set out_valid to 0 and return to ACCUM; no input beat is accepted in that same cycle.
REQ-023 Latency SHALL be one cycle from the accepted beat that completes a word to out_valid=1.
REQ-024 Unwritten bits of out_data SHALL be 0.
REQ-025 Back-to-back in_last beats SHALL each produce one bit, with no bubble required.

Reset
REQ-026 When rstn=0 at a clock edge, the block SHALL reset as follows:
- state=ACCUM, sum=0, idx=0, pack=0.
- out_valid=0, out_data=0, out_count=0, ovf=0.
- in_ready=1 on the following cycle.
REQ-027 Reset mid-neuron or during EMIT SHALL discard the partial sum, the packed bits and any pending word with no emission.

Configuration
REQ-028 Macro BNN_PACK_FLUSH_EN, when defined, SHALL apply the following flush rules in ACCUM:
- flush=1 with idx>0: emit pack with out_count=idx and go to EMIT.
- If an in_last beat is accepted in the same cycle, its bit SHALL be included first.
- flush with idx=0 and no in_last beat: no output.
- sum of a neuron in progress is retained across a flush.
- flush in EMIT is ignored.
REQ-029 Without BNN_PACK_FLUSH_EN, the flush port SHALL be present but ignored, and words SHALL be emitted only when full.

Verification
REQ-030 Saturation and compare scenario, with PACK_W=4:
- Stimulus: neuron 0 pops 100,28 with thresh 127; neuron 1 pop 64 last with thresh 64; neuron 2 pop 65 with thresh 64; neuron 3 pops 255x300 with thresh 65534.
- Response: out_data=4'b1101, out_count=4, ovf=1.
REQ-031 Backpressure scenario:
- Stimulus: the word completes while out_ready=0 for 5 cycles.
- Response: out_valid held, out_data stable, in_ready=0; after the handshake, in_ready=1.
REQ-032 Back-to-back scenario, with PACK_W=32:
- Stimulus: 32 consecutive in_last beats, pop=1, thresh=0.
- Response: out_data=32'hFFFFFFFF, out_valid exactly one cycle after the 32nd beat.
REQ-033 Flush scenario, with BNN_PACK_FLUSH_EN:
- Stimulus: 3 neurons giving bits 1,0,1, then flush.
- Response: out_data=32'h5, out_count=3.
- A flush with idx=0 produces no out_valid.
REQ-034 Reset scenario:
- Stimulus: rstn=0 after 2 chunks of a neuron and 5 packed bits.
- Response: all outputs 0; the next 32 neurons form a fresh word starting at bit 0.

Source files
------------

// File: rtl/bnn_act_packer.sv
// Binary-NN activation packer: accumulates chunk popcounts per neuron, thresholds them and packs the bits into words.
// Optional partial-word flush is compiled in with BNN_PACK_FLUSH_EN.
module bnn_act_packer #(
  parameter int unsigned POP_W  = 8,
  parameter int unsigned SUM_W  = 16,
  parameter int unsigned PACK_W = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [POP_W-1:0]           in_pop,
  input  logic                       in_last,
  input  logic [SUM_W-1:0]           in_thresh,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK_W-1:0]          out_data,
  output logic [$clog2(PACK_W):0]    out_count,
  output logic                       ovf
);

  localparam int unsigned IDX_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;
  localparam int unsigned CNT_W = $clog2(PACK_W) + 1;

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PACK_W-1:0]  pack_q, pack_d;
  logic [PACK_W-1:0]  out_data_d;
  logic [CNT_W-1:0]   out_count_d;
  logic               out_valid_d;
  logic               ovf_d;

  logic [SUM_W:0]     sum_ext;
  logic [SUM_W-1:0]   total;
  logic               sat;
  logic               act_bit;
  logic               accept;
  logic               full;
  logic [PACK_W-1:0]  pack_wr;

`ifndef BNN_PACK_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // Saturating neuron sum and strict threshold compare
  always_comb begin
    sum_ext = {1'b0, sum_q} + (SUM_W+1)'(in_pop);
    sat     = sum_ext[SUM_W];
    total   = sat ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    act_bit = (total > in_thresh);
    pack_wr = pack_q | (PACK_W'(act_bit) << idx_q);
    full    = (idx_q == IDX_W'(PACK_W - 1));
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    out_data_d  = out_data;
    out_count_d = out_count;
    out_valid_d = out_valid;
    ovf_d       = ovf;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (sat) ovf_d = 1'b1;
          if (!in_last) begin
            sum_d = total;
          end else begin
            sum_d = '0;
            if (full) begin
              out_data_d  = pack_wr;
              out_count_d = CNT_W'(PACK_W);
              out_valid_d = 1'b1;
              state_d     = EMIT;
              pack_d      = '0;
              idx_d       = '0;
            end else begin
              pack_d = pack_wr;
              idx_d  = idx_q + IDX_W'(1);
            end
          end
        end
`ifdef BNN_PACK_FLUSH_EN
        // Flush sees the bit written this cycle; the running neuron sum is kept
        if (flush && (state_d == ACCUM) && (idx_d != '0)) begin
          out_data_d  = pack_d;
          out_count_d = CNT_W'(idx_d);
          out_valid_d = 1'b1;
          state_d     = EMIT;
          pack_d      = '0;
          idx_d       = '0;
        end
`endif
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      idx_q     <= '0;
      pack_q    <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      pack_q    <= pack_d;
      out_data  <= out_data_d;
      out_count <= out_count_d;
      out_valid <= out_valid_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bnn_act_packer.sv
// Directed self-checking bench for bnn_act_packer: a 4-bit-word instance for saturation/compare,
// a 32-bit-word instance for streaming, backpressure, reset and flush.
module tb_bnn_act_packer;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 32-bit word instance
  logic        iv, irdy, il, fl, ov, ordy, ovf;
  logic [7:0]  ip;
  logic [15:0] it;
  logic [31:0] od;
  logic [5:0]  oc;

  // 4-bit word instance
  logic        iv4, irdy4, il4, ov4, ordy4, ovf4;
  logic [7:0]  ip4;
  logic [15:0] it4;
  logic [3:0]  od4;
  logic [2:0]  oc4;

  bnn_act_packer #(.POP_W(8), .SUM_W(16), .PACK_W(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(iv), .in_ready(irdy), .in_pop(ip), .in_last(il),
    .in_thresh(it), .flush(fl), .out_valid(ov), .out_ready(ordy), .out_data(od),
    .out_count(oc), .ovf(ovf)
  );

  bnn_act_packer #(.POP_W(8), .SUM_W(16), .PACK_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(iv4), .in_ready(irdy4), .in_pop(ip4), .in_last(il4),
    .in_thresh(it4), .flush(1'b0), .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
    .out_count(oc4), .ovf(ovf4)
  );

  task automatic beat(input logic [7:0] p, input logic l, input logic [15:0] t);
    @(negedge clk);
    iv = 1'b1; ip = p; il = l; it = t;
    @(posedge clk);
  endtask

  task automatic beat4(input logic [7:0] p, input logic l, input logic [15:0] t);
    @(negedge clk);
    iv4 = 1'b1; ip4 = p; il4 = l; it4 = t;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    iv = 1'b0; il = 1'b0; ip = '0;
  endtask

  task automatic handshake(input string name);
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    n_vec++;
    if (ov !== 1'b0) begin n_err++; $display("FAIL %s_ov_drop got %b want 0", name, ov); end
    n_vec++;
    if (irdy !== 1'b1) begin n_err++; $display("FAIL %s_in_ready got %b want 1", name, irdy); end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    iv = 0; il = 0; ip = '0; it = '0; fl = 0; ordy = 0;
    iv4 = 0; il4 = 0; ip4 = '0; it4 = '0; ordy4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_vec++;
    if ({ov, od, oc, ovf} !== 40'd0) begin n_err++; $display("FAIL reset_outputs got %h want 0", {ov, od, oc, ovf}); end
    n_vec++;
    if (irdy !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", irdy); end
    n_vec++;
    if ({ov4, od4, oc4, ovf4, irdy4} !== 10'b0_0000_000_0_1) begin
      n_err++; $display("FAIL reset4 got %b want 0000000001", {ov4, od4, oc4, ovf4, irdy4});
    end
  endtask

  task automatic test_saturate_compare();
    beat4(8'd100, 1'b0, 16'd0);
    beat4(8'd28, 1'b1, 16'd127);    // 128 > 127
    beat4(8'd64, 1'b1, 16'd64);     // 64 > 64 is false
    beat4(8'd65, 1'b1, 16'd64);
    @(negedge clk);
    iv4 = 1'b0;
    n_vec++;
    if (ovf4 !== 1'b0) begin n_err++; $display("FAIL sat_ovf_early got %b want 0", ovf4); end
    n_vec++;
    if (ov4 !== 1'b0) begin n_err++; $display("FAIL sat_ov_early got %b want 0", ov4); end
    for (int i = 0; i < 299; i++) beat4(8'd255, 1'b0, 16'd0);
    beat4(8'd255, 1'b1, 16'd65534);  // clamps at 65535 > 65534
    @(negedge clk);
    iv4 = 1'b0; il4 = 1'b0;
    n_vec++;
    if (ov4 !== 1'b1) begin n_err++; $display("FAIL sat_out_valid got %b want 1", ov4); end
    n_vec++;
    if (od4 !== 4'b1101) begin n_err++; $display("FAIL sat_out_data got %b want 1101", od4); end
    n_vec++;
    if (oc4 !== 3'd4) begin n_err++; $display("FAIL sat_out_count got %0d want 4", oc4); end
    n_vec++;
    if (ovf4 !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %b want 1", ovf4); end
    ordy4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy4 = 1'b0;
    n_vec++;
    if ({ov4, irdy4} !== 2'b01) begin n_err++; $display("FAIL sat_handshake got %b want 01", {ov4, irdy4}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        @(negedge clk);
        n_vec++;
        if (ov !== 1'b0) begin n_err++; $display("FAIL b2b_early_valid got %b want 0", ov); end
      end
      beat(8'd1, 1'b1, 16'd0);
    end
    @(negedge clk);  // inputs stay asserted to probe that EMIT refuses beats
    n_vec++;
    if (ov !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", ov); end
    n_vec++;
    if (od !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL b2b_data got %h want ffffffff", od); end
    n_vec++;
    if (oc !== 6'd32) begin n_err++; $display("FAIL b2b_count got %0d want 32", oc); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({ov, irdy, od} !== {2'b10, 32'hFFFF_FFFF}) begin
        n_err++; $display("FAIL bp_hold_%0d got %b/%b/%h want 1/0/ffffffff", k, ov, irdy, od);
      end
    end
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0; iv = 1'b0; il = 1'b0;
    n_vec++;
    if ({ov, irdy} !== 2'b01) begin n_err++; $display("FAIL bp_release got %b want 01", {ov, irdy}); end
  endtask

  task automatic test_threshold_pattern();
    for (int i = 0; i < 32; i++) beat(8'(i), 1'b1, 16'd15);
    idle();
    n_vec++;
    if (od !== 32'hFFFF_0000) begin n_err++; $display("FAIL pattern_data got %h want ffff0000", od); end
    n_vec++;
    if (ov !== 1'b1) begin n_err++; $display("FAIL pattern_valid got %b want 1", ov); end
    handshake("pattern");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) beat(8'd1, 1'b1, 16'd0);
    beat(8'd200, 1'b0, 16'd0);
    beat(8'd200, 1'b0, 16'd0);
    @(negedge clk);
    iv = 1'b0; rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_vec++;
    if ({ov, od, oc, ovf} !== 40'd0) begin n_err++; $display("FAIL rst_mid_outputs got %h want 0", {ov, od, oc, ovf}); end
    n_vec++;
    if (irdy !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", irdy); end
    beat(8'd5, 1'b1, 16'd100);     // would pass if the 400 partial sum survived
    for (int i = 1; i < 32; i++) beat((i % 2 == 1) ? 8'd1 : 8'd0, 1'b1, 16'd0);
    idle();
    n_vec++;
    if (od !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL rst_mid_word got %h want aaaaaaaa", od); end
    n_vec++;
    if (oc !== 6'd32) begin n_err++; $display("FAIL rst_mid_count got %0d want 32", oc); end
    handshake("rst_mid");
  endtask

  task automatic test_flush();
    beat(8'd1, 1'b1, 16'd0);
    beat(8'd0, 1'b1, 16'd0);
    beat(8'd1, 1'b1, 16'd0);
    @(negedge clk);
    iv = 1'b0; il = 1'b0; fl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fl = 1'b0;
`ifdef BNN_PACK_FLUSH_EN
    n_vec++;
    if ({ov, od, oc} !== {1'b1, 32'h5, 6'd3}) begin
      n_err++; $display("FAIL flush_word got %b/%h/%0d want 1/00000005/3", ov, od, oc);
    end
    handshake("flush");
    fl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fl = 1'b0;
    n_vec++;
    if (ov !== 1'b0) begin n_err++; $display("FAIL flush_empty got %b want 0", ov); end
`else
    n_vec++;
    if (ov !== 1'b0) begin n_err++; $display("FAIL flush_ignored got %b want 0", ov); end
    for (int i = 0; i < 29; i++) beat(8'd0, 1'b1, 16'd0);
    idle();
    n_vec++;
    if ({ov, od, oc} !== {1'b1, 32'h5, 6'd32}) begin
      n_err++; $display("FAIL flush_full_word got %b/%h/%0d want 1/00000005/32", ov, od, oc);
    end
    handshake("flush");
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_saturate_compare();
    test_back_to_back();
    test_backpressure();
    test_threshold_pattern();
    test_reset_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
